interrupt_arbiter: RTL

- Clocked, parametrised successor to the combinational 8259 priority resolver.
- Latches requests into IRR with edge or level triggering, applies masking, and resolves priority under fully-nested rules.
- Supports automatic and specific priority rotation, and runs the INT/INTA handshake that moves the winner into ISR.
- Sits between the IRQ input pins and the 8259 control logic and data-bus vector driver.

---
 rtl/interrupt_arbiter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: clocked, parametrised 8259-style priority resolver.
// It latches IRQ lines into IRR using edge or level triggering and applies the mask.
// Priority is resolved under fully-nested rules with rotating priority.
// It also runs the INT/INTA handshake that moves the winning level into ISR.
module interrupt_arbiter #(
  parameter  int N_IRQ = 8,
  localparam int ID_W  = ($clog2(N_IRQ) < 1) ? 1 : $clog2(N_IRQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             level_mode,
  input  logic [N_IRQ-1:0] interrupt_mask,
  input  logic             auto_rotate,
  input  logic             eoi_valid,
  input  logic             eoi_specific,
  input  logic [ID_W-1:0]  eoi_level,
  input  logic             set_priority_valid,
  input  logic [ID_W-1:0]  set_priority_level,
  input  logic             inta,
  output logic             int_req,
  output logic             ack_valid,
  output logic [ID_W-1:0]  ack_id,
  output logic             ack_spurious,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr,
  output logic [ID_W-1:0]  lowest_priority
);

  // One-hot seed for building single-bit masks from a level index.
  localparam logic [N_IRQ-1:0] ONE_HOT_0 = {{(N_IRQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_IRQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Result of a priority search: the winning level and its rank (0 = highest).
  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] rank;
  } pick_t;

  // Walk the rotated priority order from lowest to highest.
  // The last set bit seen is therefore the highest-priority one.
  // The level one past 'lowest' has rank 0.
  function automatic pick_t pick_highest(input logic [N_IRQ-1:0] vec,
                                         input logic [ID_W-1:0]  lowest);
    pick_t p;
    int    lvl;
    p = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      lvl = int'(lowest) + 1 + k;
      if (lvl >= N_IRQ) begin
        lvl = lvl - N_IRQ;
      end else begin
        lvl = lvl;
      end
      if (vec[lvl[ID_W-1:0]]) begin
        p.found = 1'b1;
        p.id    = ID_W'(lvl);
        p.rank  = ID_W'(k);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // State registers
  state_t           r_state;
  logic [N_IRQ-1:0] r_irr;
  logic [N_IRQ-1:0] r_isr;
  logic [N_IRQ-1:0] r_irq_prev;
  logic [ID_W-1:0]  r_lowest;
  logic             r_int_req;
  logic             r_ack_valid;
  logic [ID_W-1:0]  r_ack_id;
  logic             r_ack_spurious;

  // Combinational decisions
  state_t           w_state_next;
  pick_t            w_req_pick;
  pick_t            w_isr_pick;
  logic             w_cand_valid;
  logic             w_ack_take;
  logic             w_ack_spur;
  logic [ID_W-1:0]  w_ack_id_next;
  logic [N_IRQ-1:0] w_ack_mask;
  logic             w_eoi_hit;
  logic [ID_W-1:0]  w_eoi_id;
  logic [N_IRQ-1:0] w_eoi_clear;
  logic             w_setpri_ok;

  // Resolve the candidate and check it against the in-service nesting level.
  always_comb begin
    w_req_pick = pick_highest(r_irr & ~interrupt_mask, r_lowest);
    w_isr_pick = pick_highest(r_isr, r_lowest);
    if (w_req_pick.found && (!w_isr_pick.found || (w_req_pick.rank < w_isr_pick.rank))) begin
      w_cand_valid = 1'b1;
    end else begin
      w_cand_valid = 1'b0;
    end
  end

  // Decide which ISR bit an EOI command clears, based on the pre-edge ISR.
  always_comb begin
    w_eoi_hit   = 1'b0;
    w_eoi_id    = '0;
    w_eoi_clear = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        if ((int'(eoi_level) < N_IRQ) && r_isr[eoi_level]) begin
          w_eoi_hit   = 1'b1;
          w_eoi_id    = eoi_level;
          w_eoi_clear = ONE_HOT_0 << eoi_level;
        end else begin
          w_eoi_hit = 1'b0;
        end
      end else begin
        if (w_isr_pick.found) begin
          w_eoi_hit   = 1'b1;
          w_eoi_id    = w_isr_pick.id;
          w_eoi_clear = ONE_HOT_0 << w_isr_pick.id;
        end else begin
          w_eoi_hit = 1'b0;
        end
      end
    end else begin
      w_eoi_hit = 1'b0;
    end
  end

  // Out-of-range rotation targets are dropped so that lowest_priority always names a real level.
  always_comb begin
    if (set_priority_valid && (int'(set_priority_level) < N_IRQ)) begin
      w_setpri_ok = 1'b1;
    end else begin
      w_setpri_ok = 1'b0;
    end
  end

  // Handshake FSM next-state logic and the acknowledge decision.
  always_comb begin
    w_state_next  = r_state;
    w_ack_take    = 1'b0;
    w_ack_spur    = 1'b0;
    w_ack_id_next = '0;
    w_ack_mask    = '0;
    case (r_state)
      ST_IDLE: begin
        if (inta) begin
          w_state_next = ST_ACK;
          w_ack_spur   = 1'b1;
        end else if (w_cand_valid) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (inta) begin
          w_state_next = ST_ACK;
          if (w_cand_valid) begin
            w_ack_take = 1'b1;
          end else begin
            w_ack_spur = 1'b1;
          end
        end else if (!w_cand_valid) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_ACK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_ack_take) begin
      w_ack_id_next = w_req_pick.id;
      w_ack_mask    = ONE_HOT_0 << w_req_pick.id;
    end else if (w_ack_spur) begin
      w_ack_id_next = LAST_ID;
    end else begin
      w_ack_id_next = '0;
    end
  end

  // Handshake state register plus registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_int_req      <= 1'b0;
      r_ack_valid    <= 1'b0;
      r_ack_id       <= '0;
      r_ack_spurious <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_int_req      <= (w_state_next == ST_REQ);
      r_ack_valid    <= (w_state_next == ST_ACK);
      r_ack_id       <= w_ack_id_next;
      r_ack_spurious <= w_ack_spur;
    end
  end

  // IRR capture: edge mode holds bits until acknowledged, level mode follows the pins.
  // In edge mode a new edge overrides the clear for the acknowledged level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_irr      <= '0;
    end else begin
      r_irq_prev <= irq_in;
      if (level_mode) begin
        r_irr <= irq_in;
      end else begin
        r_irr <= (r_irr & ~w_ack_mask) | (irq_in & ~r_irq_prev);
      end
    end
  end

  // ISR update: the EOI clear is applied first, so a same-cycle acknowledge set wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_isr <= '0;
    end else begin
      r_isr <= (r_isr & ~w_eoi_clear) | w_ack_mask;
    end
  end

  // Priority rotation: an explicit set-priority takes precedence over auto-rotate on EOI.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lowest <= LAST_ID;
    end else if (w_setpri_ok) begin
      r_lowest <= set_priority_level;
    end else if (auto_rotate && w_eoi_hit) begin
      r_lowest <= w_eoi_id;
    end else begin
      r_lowest <= r_lowest;
    end
  end

  assign int_req         = r_int_req;
  assign ack_valid       = r_ack_valid;
  assign ack_id          = r_ack_id;
  assign ack_spurious    = r_ack_spurious;
  assign irr             = r_irr;
  assign isr             = r_isr;
  assign lowest_priority = r_lowest;

endmodule
